// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the single-port data memory
module dmem_arbiter #(
    parameter int DEPTH     = 1024,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  MAX_B   = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state;
    logic        owner;
    logic [3:0]  burst_cnt;

    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic [31:0] rd_val;

    // owner holds the last-served port, so an IDLE tie goes to the other one
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (p0_req && p1_req) begin
                        p0_gnt = owner;
                        p1_gnt = !owner;
                    end else begin
                        p0_gnt = p0_req;
                        p1_gnt = p1_req;
                    end
                end
                OWN0: begin
                    if (p0_req && (burst_cnt < MAX_B || !p1_req))
                        p0_gnt = 1'b1;
                    else if (p1_req)
                        p1_gnt = 1'b1;
                end
                OWN1: begin
                    if (p1_req && (burst_cnt < MAX_B || !p0_req))
                        p1_gnt = 1'b1;
                    else if (p0_req)
                        p0_gnt = 1'b1;
                end
                default: begin
                    p0_gnt = 1'b0;
                    p1_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        any_gnt   = p0_gnt | p1_gnt;
        sel_we    = p1_gnt ? p1_we    : p0_we;
        sel_addr  = p1_gnt ? p1_addr  : p0_addr;
        sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
        in_range  = sel_addr < DEPTH_W;
        mem_a     = any_gnt ? sel_addr  : 32'd0;
        mem_wd    = any_gnt ? sel_wdata : 32'd0;
        mem_we    = any_gnt & sel_we & in_range;
        rd_val    = (sel_we || !in_range) ? 32'd0 : mem_rd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b1;
            burst_cnt <= 4'd0;
        end else if (any_gnt) begin
            if (state != IDLE && p1_gnt == owner)
                burst_cnt <= (burst_cnt >= MAX_B) ? MAX_B : burst_cnt + 4'd1;
            else
                burst_cnt <= 4'd1;
            owner <= p1_gnt;
            state <= p1_gnt ? OWN1 : OWN0;
        end else begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end
    end

    // Non-granted port keeps its last rdata; rvalid/err are single-cycle pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= 32'd0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= 32'd0;
        end else begin
            p0_rvalid <= p0_gnt;
            p0_err    <= p0_gnt & !in_range;
            if (p0_gnt)
                p0_rdata <= rd_val;
            p1_rvalid <= p1_gnt;
            p1_err    <= p1_gnt & !in_range;
            if (p1_gnt)
                p1_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [0:1023];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(1024), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    // Out-of-range reads return a poison pattern so a leaked read is visible
    always_comb mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'hBAD0_BAD0;

    always @(posedge clk)
        if (mem_we) mem[mem_a[9:0]] <= mem_wd;

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mwe;
        logic [31:0] ma, mwd;
        logic        v0;
        logic [31:0] q0;
        logic        e0, v1;
        logic [31:0] q1;
        logic        e1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic g0, input logic g1, input logic mwe,
                       input logic [31:0] ma, input logic [31:0] mwd, input logic v0,
                       input logic [31:0] q0, input logic e0, input logic v1,
                       input logic [31:0] q1, input logic e1);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
        v.v0 = v0; v.q0 = q0; v.e0 = e0; v.v1 = v1; v.q1 = q1; v.e1 = e1;
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, got, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        rst = rs; p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    localparam logic [31:0] M10 = 32'hA000_0010;
    localparam logic [31:0] M20 = 32'hA000_0020;
    localparam logic [31:0] M05 = 32'hA000_0005;
    localparam logic [31:0] M00 = 32'hA000_0000;
    localparam logic [31:0] M3FF = 32'hA000_03FF;
    localparam logic [31:0] CAFE = 32'hCAFE_F00D;

    initial begin
        logic exp_seq [6];
        logic seq_r1 [6];

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);

        //   rst r0 w0 a0 d0  r1 w1 a1 d1  | g0 g1 mwe ma mwd | v0 q0 e0 v1 q1 e1
        for (int i = 0; i < 3; i++)
            add(0, 1,0,16,0, 1,0,32,0,       0,0,0,0,0,        0,0,0, 0,0,0);
        add(1, 1,1,8,32'h123, 0,0,0,0,       1,0,1,8,32'h123,  0,0,0, 0,0,0);
        add(1, 1,0,8,0, 0,0,0,0,             1,0,0,8,0,        1,0,0, 0,0,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        1,32'h123,0, 0,0,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        0,32'h123,0, 0,0,0);
        add(0, 1,0,16,0, 1,0,32,0,           0,0,0,0,0,        0,32'h123,0, 0,0,0);
        add(1, 1,0,16,0, 1,0,32,0,           1,0,0,16,0,       0,0,0, 0,0,0);
        for (int i = 0; i < 3; i++)
            add(1, 1,0,16,0, 1,0,32,0,       1,0,0,16,0,       1,M10,0, 0,0,0);
        add(1, 1,0,16,0, 1,0,32,0,           0,1,0,32,0,       1,M10,0, 0,0,0);
        for (int i = 0; i < 3; i++)
            add(1, 1,0,16,0, 1,0,32,0,       0,1,0,32,0,       0,M10,0, 1,M20,0);
        add(1, 1,0,16,0, 1,0,32,0,           1,0,0,16,0,       0,M10,0, 1,M20,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        1,M10,0, 0,M20,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        0,M10,0, 0,M20,0);
        add(1, 0,0,0,0, 1,0,5,0,             0,1,0,5,0,        0,M10,0, 0,M20,0);
        for (int i = 0; i < 9; i++)
            add(1, 0,0,0,0, 1,0,5,0,         0,1,0,5,0,        0,M10,0, 1,M05,0);
        add(1, 1,0,16,0, 1,0,5,0,            1,0,0,16,0,       0,M10,0, 1,M05,0);
        add(1, 0,0,0,0, 1,0,5,0,             0,1,0,5,0,        1,M10,0, 0,M05,0);
        add(1, 0,0,0,0, 1,1,1024,32'hDEAD,   0,1,0,1024,32'hDEAD, 0,M10,0, 1,M05,0);
        add(1, 0,0,0,0, 1,0,0,0,             0,1,0,0,0,        0,M10,0, 1,0,1);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        0,M10,0, 1,M00,0);
        add(1, 1,0,32'hFFFF_FFFF,0, 0,0,0,0, 1,0,0,32'hFFFF_FFFF,0, 0,M10,0, 0,M00,0);
        add(1, 1,0,1023,0, 0,0,0,0,          1,0,0,1023,0,     1,0,1, 0,M00,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        1,M3FF,0, 0,M00,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        0,M3FF,0, 0,M00,0);
        add(1, 0,0,0,0, 1,1,100,CAFE,        0,1,1,100,CAFE,   0,M3FF,0, 0,M00,0);
        add(1, 0,0,0,0, 1,0,100,0,           0,1,0,100,0,      0,M3FF,0, 1,0,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        0,M3FF,0, 1,CAFE,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        0,M3FF,0, 0,CAFE,0);
        add(1, 1,0,16,0, 0,0,0,0,            1,0,0,16,0,       0,M3FF,0, 0,CAFE,0);
        add(0, 1,0,16,0, 1,0,32,0,           0,0,0,0,0,        1,M10,0, 0,CAFE,0);
        add(1, 1,0,16,0, 1,0,32,0,           1,0,0,16,0,       0,0,0, 0,0,0);
        add(1, 0,0,0,0, 0,0,0,0,             0,0,0,0,0,        1,M10,0, 0,0,0);

        drive(0, 0,0,0,0, 0,0,0,0);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            #1;
            n_vec++;
            chk(i, "p0_gnt", 32'(p0_gnt), 32'(vecs[i].g0));
            chk(i, "p1_gnt", 32'(p1_gnt), 32'(vecs[i].g1));
            chk(i, "mem_we", 32'(mem_we), 32'(vecs[i].mwe));
            chk(i, "mem_a", mem_a, vecs[i].ma);
            chk(i, "mem_wd", mem_wd, vecs[i].mwd);
            chk(i, "p0_rvalid", 32'(p0_rvalid), 32'(vecs[i].v0));
            chk(i, "p0_rdata", p0_rdata, vecs[i].q0);
            chk(i, "p0_err", 32'(p0_err), 32'(vecs[i].e0));
            chk(i, "p1_rvalid", 32'(p1_rvalid), 32'(vecs[i].v1));
            chk(i, "p1_rdata", p1_rdata, vecs[i].q1);
            chk(i, "p1_err", 32'(p1_err), 32'(vecs[i].e1));
        end

        // p1 joins partway through a p0 burst: p0 finishes its quota of 4, then p1, then p0 alone
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        seq_r1  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1, 1,0,16,0, seq_r1[c],0,32,0);
            #1;
            n_vec++;
            chk(100 + c, "join_p1_gnt", 32'(p1_gnt), 32'(exp_seq[c]));
            chk(100 + c, "join_p0_gnt", 32'(p0_gnt), 32'(!exp_seq[c]));
        end

        @(negedge clk);
        drive(1, 0,0,0,0, 0,0,0,0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
